branch_history_table: RTL
=========================

Name: branch_history_table

Overview:
- Per-PC table of 2-bit saturating direction counters, trained by the resolved-branch output of the execute-stage branch unit.
- Queried combinationally by the frontend with the fetch virtual PC; supplies the taken/not-taken prediction used for conditional branches.
- Sits directly downstream of the branch unit (consumes its resolve packet) and upstream of the fetch-PC select logic.

Parameters:
- VLEN, 64, virtual address width in bits.
- NR_ENTRIES, 1024, number of table entries; power of two, >= 2.
- ROW_OFFSET, 2, PC bits dropped below the index (word-aligned instructions).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_bht_i  input  1  invalidate all entries (fence.i / context switch).
- vpc_i  input  VLEN  fetch PC to predict for.
- bht_valid_o  output  1  entry at vpc_i holds trained state.
- bht_taken_o  output  1  predicted direction (counter MSB); 0 when bht_valid_o=0.
- update_valid_i  input  1  resolve packet valid (resolved_branch.valid).
- update_pc_i  input  VLEN  PC of the resolved instruction.
- update_is_branch_i  input  1  cf_type == Branch (conditional branch).
- update_taken_i  input  1  resolved is_taken.
- update_mispredict_i  input  1  resolved is_mispredict; used only by the optional feature.

Behaviour:
- Index = PC[ROW_OFFSET+log2(NR_ENTRIES)-1 : ROW_OFFSET]; identical function for vpc_i and update_pc_i. Upper PC bits ignored (aliasing permitted, no tag).
- Storage per entry: valid bit + 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T), in flops.
- Reset (async, rst_ni=0): all valid=0, all counters=00; bht_valid_o=0, bht_taken_o=0 immediately.
- Lookup is combinational, zero latency: bht_valid_o = valid[idx]; bht_taken_o = valid[idx] & counter[idx][1].
- Update is accepted when update_valid_i & update_is_branch_i. Non-branch packets (JALR, Return, NoCF) are ignored; no handshake, always ready.
- Update on an invalid entry: valid<=1; counter<=10 if taken, else 01.
- Update on a valid entry, taken: counter<=min(counter+1, 11).
- Update on a valid entry, not taken: counter<=max(counter-1, 00). Saturates at both ends and never wraps.
- Update is written on the next rising edge (1-cycle write latency).
- Lookup at the same index in the update cycle returns the pre-update value; the new value is visible from the following cycle.
- flush_bht_i=1: all valid<=0 on the next edge. Counters may keep stale values but are unobservable, because bht_taken_o is gated by valid.
- Flush and update in the same cycle: flush wins; the update is dropped and the entry ends invalid.
- One update per cycle maximum; different-index lookup and update proceed independently.
- Reset asserted mid-operation: pending update is discarded and the state matches power-on.

Optional Feature:
- Macro: BHT_STATS_EN.
- Defined:
  - Extra outputs stat_updates_o (32 bits) and stat_mispredicts_o (32 bits).
  - stat_updates_o increments on every accepted update; stat_mispredicts_o increments on every accepted update with update_mispredict_i=1.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are not cleared by flush_bht_i.
- Undefined: ports and counters absent; update_mispredict_i is unused; behaviour otherwise identical.

Test Plan:
- Reset, then lookup vpc_i=64'h8000_0000 -> bht_valid_o=0, bht_taken_o=0; assert rst_ni low mid-run -> outputs drop to 0 combinationally.
- Taken update at PC 64'h8000_0010, then lookup same PC next cycle -> valid=1, taken=1 (counter 10). Three more taken updates -> counter 11, holds at 11.
- From 11, four not-taken updates at 64'h8000_0010 -> counter 10,01,00,00; taken output 1,0,0,0.
- Update and lookup on 64'h8000_0020 in the same cycle -> lookup shows old state (valid=0); the next cycle shows valid=1.
- Aliasing, with NR_ENTRIES=1024: PCs 64'h8000_0010 and 64'h8000_1010 map to the same index -> update via one is seen on the other. JALR packet (update_is_branch_i=0) -> no change.
- flush_bht_i and a taken update at 64'h8000_0030 in the same cycle -> next cycle valid=0 for all PCs. With BHT_STATS_EN: 5 updates with 2 mispredicts -> stat_updates_o=5, stat_mispredicts_o=2, unchanged by flush.

Source files
------------

// File: rtl/branch_history_table_if.sv
// Frontend lookup and branch-unit resolve signals for branch_history_table.
// Optional statistics outputs are present only when BHT_STATS_EN is defined.
interface branch_history_table_if #(
  parameter int unsigned VLEN = 64
);
  logic            flush_bht_i;
  logic [VLEN-1:0] vpc_i;
  logic            bht_valid_o;
  logic            bht_taken_o;
  logic            update_valid_i;
  logic [VLEN-1:0] update_pc_i;
  logic            update_is_branch_i;
  logic            update_taken_i;
  logic            update_mispredict_i;
`ifdef BHT_STATS_EN
  logic [31:0]     stat_updates_o;
  logic [31:0]     stat_mispredicts_o;
`endif

  modport master (
    output flush_bht_i,
    output vpc_i,
    input  bht_valid_o,
    input  bht_taken_o,
    output update_valid_i,
    output update_pc_i,
    output update_is_branch_i,
    output update_taken_i,
    output update_mispredict_i
`ifdef BHT_STATS_EN
    ,
    input  stat_updates_o,
    input  stat_mispredicts_o
`endif
  );

  modport slave (
    input  flush_bht_i,
    input  vpc_i,
    output bht_valid_o,
    output bht_taken_o,
    input  update_valid_i,
    input  update_pc_i,
    input  update_is_branch_i,
    input  update_taken_i,
    input  update_mispredict_i
`ifdef BHT_STATS_EN
    ,
    output stat_updates_o,
    output stat_mispredicts_o
`endif
  );
endinterface

// File: rtl/branch_history_table.sv
// Untagged per-PC table of 2-bit saturating direction counters with zero-latency lookup.
// Define BHT_STATS_EN to add saturating update / mispredict counters.
module branch_history_table #(
  parameter int unsigned VLEN       = 64,
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned ROW_OFFSET = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  branch_history_table_if.slave bht
);
  localparam int unsigned IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

  logic [VLEN-1:0]  lookup_pc;
  logic [VLEN-1:0]  update_pc;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic             update_en;

  logic             valid_q [NR_ENTRIES];
  logic [1:0]       ctr_q   [NR_ENTRIES];

  logic             upd_valid_cur;
  logic [1:0]       upd_ctr_cur;
  logic [1:0]       upd_ctr_next;

  assign lookup_pc  = bht.vpc_i;
  assign update_pc  = bht.update_pc_i;
  assign lookup_idx = lookup_pc[ROW_OFFSET +: IDX_W];
  assign update_idx = update_pc[ROW_OFFSET +: IDX_W];
  assign update_en  = bht.update_valid_i & bht.update_is_branch_i;

  // Upper PC bits are intentionally ignored (aliasing, no tag).
  logic unused_inputs;
`ifdef BHT_STATS_EN
  assign unused_inputs = ^{lookup_pc, update_pc};
`else
  assign unused_inputs = ^{lookup_pc, update_pc, bht.update_mispredict_i};
`endif

  assign bht.bht_valid_o = valid_q[lookup_idx];
  assign bht.bht_taken_o = valid_q[lookup_idx] & ctr_q[lookup_idx][1];

  always_comb begin
    upd_valid_cur = valid_q[update_idx];
    upd_ctr_cur   = ctr_q[update_idx];
    upd_ctr_next  = upd_ctr_cur;
    if (!upd_valid_cur) begin
      upd_ctr_next = bht.update_taken_i ? 2'b10 : 2'b01;
    end else if (bht.update_taken_i) begin
      upd_ctr_next = (upd_ctr_cur == 2'b11) ? 2'b11 : upd_ctr_cur + 2'd1;
    end else begin
      upd_ctr_next = (upd_ctr_cur == 2'b00) ? 2'b00 : upd_ctr_cur - 2'd1;
    end
  end

  // Flush has priority over a same-cycle update; counters are left stale since valid gates them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
    end else if (bht.flush_bht_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (update_en) begin
      valid_q[update_idx] <= 1'b1;
      ctr_q[update_idx]   <= upd_ctr_next;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] stat_updates_q;
  logic [31:0] stat_mispredicts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else if (update_en) begin
      if (stat_updates_q != '1) begin
        stat_updates_q <= stat_updates_q + 32'd1;
      end
      if (bht.update_mispredict_i && (stat_mispredicts_q != '1)) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign bht.stat_updates_o     = stat_updates_q;
  assign bht.stat_mispredicts_o = stat_mispredicts_q;
`endif
endmodule
